// File: rtl/jimbo_mem_responder.sv
// -----------------------------------------------------------------------------
// jimbo_mem_responder
//
// Memory-side responder for the Jimbo 4-bit CPU external bus. It owns a
// 2**ADDR_W x DATA_W RAM and runs a small life cycle:
//   IDLE/LOAD : accept a nibble stream from the program loader into RAM
//   RUN       : release the CPU from reset and serve its reads and writes
//   HALT      : the CPU touched HALT_ADDR; the CPU is parked and writes are ignored
//   DUMP/DONE : stream the whole RAM out for checking (optional feature)
//
// Optional feature macro: JIMBO_MEM_DUMP_EN
//   defined     : HALT moves on to DUMP, which streams every RAM word, then DONE
//   not defined : HALT is terminal; dump_valid/dump_addr/dump_data are tied to 0
//
// Ports
//   clk, rst_n             clock; synchronous active-low reset
//   cpu_addr/rw/wdata      CPU bus in (rw: 1 = write, 0 = read)
//   cpu_rdata              read data to the CPU, combinational from the RAM
//   cpu_rst_n              CPU reset, high only while in RUN
//   ld_valid/data/last     loader nibble stream in
//   ld_ready               high in IDLE/LOAD
//   halted                 high in HALT/DUMP/DONE
//   dump_valid/addr/data   dump stream out
//   dump_ready             dump consumer ready
//
// The RAM is never cleared by rst_n, so data loaded or written before a reset
// is still there afterwards.
// -----------------------------------------------------------------------------
module jimbo_mem_responder #(
    parameter int unsigned       ADDR_W    = 11,
    parameter int unsigned       DATA_W    = 4,
    parameter logic [ADDR_W-1:0] HALT_ADDR = 11'h7FF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_rw,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rst_n,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              halted,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    input  logic              dump_ready
);

    localparam int unsigned       DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_HALT,
        ST_DUMP,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ld_ptr_q, ld_ptr_d;

    logic [DATA_W-1:0] mem [DEPTH];

    // One shared write port: the loader owns it in IDLE/LOAD, the CPU in RUN.
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic ld_beat;
    assign ld_beat = ld_valid & ld_ready;

`ifdef JIMBO_MEM_DUMP_EN
    logic [ADDR_W-1:0] dump_ptr_q, dump_ptr_d;

    always_comb begin
        dump_ptr_d = dump_ptr_q;
        // Pointer holds on the final word so it never wraps back to 0.
        if (state_q == ST_DUMP && dump_ready && dump_ptr_q != LAST_ADDR) begin
            dump_ptr_d = dump_ptr_q + 1'b1;
        end
        if (!rst_n) begin
            dump_ptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        dump_ptr_q <= dump_ptr_d;
    end

    assign dump_valid = (state_q == ST_DUMP);
    assign dump_addr  = dump_valid ? dump_ptr_q : '0;
    assign dump_data  = dump_valid ? mem[dump_ptr_q] : '0;
`else
    logic unused_dump_ready;
    assign unused_dump_ready = dump_ready;
    assign dump_valid        = 1'b0;
    assign dump_addr         = '0;
    assign dump_data         = '0;
`endif

    // Next-state, loader pointer and RAM write port.
    always_comb begin
        state_d   = state_q;
        ld_ptr_d  = ld_ptr_q;
        mem_we    = 1'b0;
        mem_waddr = ld_ptr_q;
        mem_wdata = ld_data;

        case (state_q)
            ST_IDLE, ST_LOAD: begin
                if (ld_beat) begin
                    mem_we = 1'b1;
                    // A beat into the last address ends the load even without
                    // ld_last, so the loader can never wrap over word 0.
                    if (ld_last || ld_ptr_q == LAST_ADDR) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d  = ST_LOAD;
                        ld_ptr_d = ld_ptr_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (cpu_rw) begin
                    mem_we    = 1'b1;
                    mem_waddr = cpu_addr;
                    mem_wdata = cpu_wdata;
                end
                // A write to HALT_ADDR in this cycle still commits above.
                if (cpu_addr == HALT_ADDR) begin
                    state_d = ST_HALT;
                end
            end
`ifdef JIMBO_MEM_DUMP_EN
            ST_HALT: state_d = ST_DUMP;
            ST_DUMP: begin
                if (dump_ready && dump_ptr_q == LAST_ADDR) begin
                    state_d = ST_DONE;
                end
            end
`endif
            default: ;
        endcase

        if (!rst_n) begin
            state_d  = ST_IDLE;
            ld_ptr_d = '0;
            mem_we   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        state_q  <= state_d;
        ld_ptr_q <= ld_ptr_d;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // cpu_rst_n decodes the registered state, so the CPU's first cycle is the
    // one after RUN is entered.
    assign cpu_rst_n = (state_q == ST_RUN);
    assign ld_ready  = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    assign halted    = (state_q == ST_HALT) || (state_q == ST_DUMP) || (state_q == ST_DONE);
    assign cpu_rdata = (state_q == ST_RUN && !cpu_rw) ? mem[cpu_addr] : '0;

endmodule

// File: tb/tb_jimbo_mem_responder.sv
`timescale 1ns/1ps
module tb_jimbo_mem_responder;

    localparam int DEPTH = 2048;
    localparam logic [10:0] HALT_A = 11'h7FF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] cpu_addr;
    logic        cpu_rw;
    logic [3:0]  cpu_wdata;
    logic [3:0]  cpu_rdata;
    logic        cpu_rst_n;
    logic        ld_valid;
    logic [3:0]  ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        halted;
    logic        dump_valid;
    logic [10:0] dump_addr;
    logic [3:0]  dump_data;
    logic        dump_ready;

    always #5 clk = ~clk;

    jimbo_mem_responder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_addr   (cpu_addr),
        .cpu_rw     (cpu_rw),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_rst_n  (cpu_rst_n),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .halted     (halted),
        .dump_valid (dump_valid),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data),
        .dump_ready (dump_ready)
    );

    // ---------------- reference model (behavioural) ----------------
    logic [3:0] ref_mem [DEPTH];
    bit         ref_known [DEPTH];
    int         m_ldptr;

    // ---------------- scoreboard ----------------
    typedef enum int {K_RDATA, K_CPURST, K_LDRDY, K_HALTED, K_DVALID} kind_e;
    typedef struct {
        int    cyc;
        kind_e kind;
        int    val;
        string name;
    } exp_t;
    typedef struct {
        int addr;
        int data;
    } dexp_t;

    exp_t  exp_q[$];
    dexp_t dump_q[$];
    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;
    int    dump_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_now(kind_e k, int v, string n);
        exp_t e;
        e.cyc  = cyc;
        e.kind = k;
        e.val  = v;
        e.name = n;
        exp_q.push_back(e);
    endtask

    // Output monitor: compares every expectation belonging to the current cycle.
    initial begin
        exp_t e;
        int   act;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                case (e.kind)
                    K_RDATA:  act = int'(cpu_rdata);
                    K_CPURST: act = int'(cpu_rst_n);
                    K_LDRDY:  act = int'(ld_ready);
                    K_HALTED: act = int'(halted);
                    default:  act = int'(dump_valid);
                endcase
                checks++;
                if (e.cyc != cyc || act != e.val) begin
                    failures++;
                    $display("FAIL %s: got %0d expected %0d (cycle %0d, queued for %0d)",
                             e.name, act, e.val, cyc, e.cyc);
                end else begin
                    $display("ok   %s = %0d (cycle %0d)", e.name, act, cyc);
                end
            end
        end
    end

    // Dump monitor: pops on each beat, and checks stability while stalled.
    initial begin
        dexp_t d;
        bit          stall_prev = 1'b0;
        logic [10:0] stall_addr = '0;
        logic [3:0]  stall_data = '0;
        forever begin
            @(negedge clk);
            if (stall_prev && dump_valid) begin
                checks++;
                if (dump_addr !== stall_addr || dump_data !== stall_data) begin
                    failures++;
                    $display("FAIL dump_stable: got %h/%h expected %h/%h",
                             dump_addr, dump_data, stall_addr, stall_data);
                end
            end
            stall_prev = dump_valid && !dump_ready;
            stall_addr = dump_addr;
            stall_data = dump_data;
            if (dump_valid && dump_ready) begin
                checks++;
                if (dump_q.size() == 0) begin
                    failures++;
                    $display("FAIL dump_extra: got beat addr %h expected none", dump_addr);
                end else begin
                    d = dump_q.pop_front();
                    if (int'(dump_addr) != d.addr || int'(dump_data) != d.data) begin
                        failures++;
                        $display("FAIL dump_beat: got %h/%h expected %h/%h",
                                 dump_addr, dump_data, d.addr[10:0], d.data[3:0]);
                    end else if (d.addr < 4 || d.addr == 16 || d.addr == 2047) begin
                        $display("ok   dump_beat addr %h data %h", dump_addr, dump_data);
                    end
                end
                dump_seen++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_idle();
        cpu_rw = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    endtask

    task automatic do_reset(int n);
        rst_n = 1'b0; ld_valid = 1'b0; dump_ready = 1'b0;
        cpu_idle();
        repeat (n) tick();
        rst_n = 1'b1;
        m_ldptr = 0;
        expect_now(K_CPURST, 0, "rst_cpu_rst_n");
        expect_now(K_LDRDY,  1, "rst_ld_ready");
        expect_now(K_HALTED, 0, "rst_halted");
        expect_now(K_DVALID, 0, "rst_dump_valid");
        expect_now(K_RDATA,  0, "rst_cpu_rdata");
    endtask

    task automatic load_beat(logic [3:0] d, logic last, bit chk);
        ld_valid = 1'b1; ld_data = d; ld_last = last;
        if (chk) begin
            expect_now(K_LDRDY,  1, "load_ld_ready");
            expect_now(K_CPURST, 0, "load_cpu_rst_n");
        end
        ref_mem[m_ldptr]   = d;
        ref_known[m_ldptr] = 1'b1;
        m_ldptr++;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    task automatic expect_run(string n);
        expect_now(K_CPURST, 1, n);
        expect_now(K_LDRDY,  0, "run_ld_ready");
        expect_now(K_HALTED, 0, "run_halted");
    endtask

    task automatic cpu_read(logic [10:0] a, string n);
        cpu_rw = 1'b0; cpu_addr = a;
        expect_now(K_RDATA, int'(ref_mem[a]), n);
        tick();
    endtask

    task automatic cpu_write(logic [10:0] a, logic [3:0] d);
        cpu_rw = 1'b1; cpu_addr = a; cpu_wdata = d;
        expect_now(K_RDATA, 0, "wr_cpu_rdata");
        ref_mem[a]   = d;
        ref_known[a] = 1'b1;
        tick();
    endtask

    task automatic random_ops(int n, int lo, int hi);
        logic [10:0] a;
        for (int i = 0; i < n; i++) begin
            a = 11'($urandom_range(hi, lo));
            if (($urandom % 2) == 1 || !ref_known[a]) cpu_write(a, 4'($urandom));
            else cpu_read(a, "rand_read");
        end
        cpu_idle();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [3:0] prog [4];
        prog = '{4'hA, 4'h3, 4'hF, 4'h1};
        ld_data = '0; ld_last = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_known[i] = 1'b0;

        // Reset, then a short program with ld_last on the 4th nibble.
        do_reset(2);
        tick();
        for (int i = 0; i < 4; i++) load_beat(prog[i], (i == 3), 1'b1);
        expect_run("load4_cpu_rst_n");
        for (int i = 0; i < 4; i++) cpu_read(11'(i), "load4_mem");
        cpu_write(11'h010, 4'h5);
        cpu_read(11'h010, "raw_read_010");
        cpu_read(11'h002, "read_002");
        random_ops(30, 'h030, 'h06F);

        // ld_valid while running must not touch RAM or state.
        cpu_write(11'h004, 4'hC);
        ld_valid = 1'b1; ld_data = 4'h3; ld_last = 1'b1;
        cpu_read(11'h000, "ignored_ld_read0");
        ld_valid = 1'b0; ld_last = 1'b0;
        expect_run("ignored_ld_cpu_rst_n");
        cpu_read(11'h004, "ignored_ld_mem4");

        // Reset in the middle of RUN after two writes.
        cpu_write(11'h020, 4'h7);
        cpu_write(11'h021, 4'h2);
        do_reset(1);
        tick();
        load_beat(4'h8, 1'b1, 1'b1);
        expect_run("reload_cpu_rst_n");
        cpu_read(11'h020, "retain_020");
        cpu_read(11'h021, "retain_021");
        cpu_read(11'h001, "retain_001");
        cpu_read(11'h000, "reload_000");

        // Full-depth load without ld_last: ends at the last address, no wrap.
        do_reset(1);
        tick();
        for (int i = 0; i < DEPTH; i++)
            load_beat((i < 4) ? prog[i] : 4'($urandom), 1'b0, (i == 0 || i == DEPTH - 1));
        expect_run("fullload_cpu_rst_n");
        cpu_write(11'h010, 4'h5);
        cpu_read(11'h010, "full_raw_010");
        cpu_read(11'h002, "full_read_002");
        cpu_read(11'h7FE, "full_read_7fe");
        random_ops(20, 'h100, 'h1FF);

        // Halt by writing HALT_ADDR; the write still commits.
        cpu_write(HALT_A, 4'h9);
        cpu_rw = 1'b1; cpu_addr = 11'h010; cpu_wdata = 4'h0;   // must be ignored
        expect_now(K_HALTED, 1, "halt_halted");
        expect_now(K_CPURST, 0, "halt_cpu_rst_n");
        tick();
        cpu_rw = 1'b0; cpu_addr = 11'h002;
        expect_now(K_RDATA, 0, "halt_cpu_rdata");
        expect_now(K_HALTED, 1, "halt_halted2");
`ifdef JIMBO_MEM_DUMP_EN
        expect_now(K_DVALID, 1, "dump_valid_start");
        for (int i = 0; i < DEPTH; i++) begin
            dexp_t d;
            d.addr = i;
            d.data = int'(ref_mem[i]);
            dump_q.push_back(d);
        end
        begin
            int budget = 0;
            while (dump_seen < DEPTH && budget < 5000) begin
                dump_ready = budget[0];
                tick();
                budget++;
            end
            dump_ready = 1'b0;
            if (dump_seen < DEPTH) begin
                failures++;
                $display("FAIL dump_timeout: got %0d beats expected %0d", dump_seen, DEPTH);
            end
        end
        expect_now(K_DVALID, 0, "done_dump_valid");
        expect_now(K_HALTED, 1, "done_halted");
        tick();
        expect_now(K_DVALID, 0, "done_dump_valid2");
`else
        tick();
        expect_now(K_DVALID, 0, "nodump_dump_valid");
        expect_now(K_HALTED, 1, "halt_terminal");
        expect_now(K_CPURST, 0, "halt_terminal_cpu_rst_n");
        tick();
        tick();
        expect_now(K_HALTED, 1, "halt_terminal2");
`endif
        cpu_idle();
        tick();

        // After reset the RAM still holds the pre-halt image.
        do_reset(1);
        tick();
        load_beat(4'hB, 1'b1, 1'b0);
        expect_run("final_cpu_rst_n");
        cpu_read(11'h010, "halt_write_ignored_010");
        cpu_read(11'h003, "final_read_003");
        cpu_read(HALT_A, "final_read_7ff");
        cpu_idle();
        expect_now(K_HALTED, 1, "read_halt_halted");
        tick();
        tick();

        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
